// File: rtl/jtkiwi_obj_pkg.sv
// Shared definitions for the object-table scanner: FSM states, request FIFO
// entry layout and default vertical blanking window.
package jtkiwi_obj_pkg;

    typedef enum logic [1:0] {
        CHK  = 2'd0,
        A0   = 2'd1,
        A1   = 2'd2,
        PUSH = 2'd3
    } scan_state_t;

    localparam int PAL_W  = 5;
    localparam int XPOS_W = 9;

    localparam logic [8:0] VB_START_DEF = 9'hf0;
    localparam logic [8:0] VB_END_DEF   = 9'h116;

    // Entry layout, LSB first: ysub, xpos, vflip, hflip, pal, code
    localparam int YSUB_OFF = 0;

    function automatic int xpos_off(input int hbits);
        return hbits;
    endfunction

    function automatic int vflip_off(input int hbits);
        return hbits + XPOS_W;
    endfunction

    function automatic int hflip_off(input int hbits);
        return hbits + XPOS_W + 1;
    endfunction

    function automatic int pal_off(input int hbits);
        return hbits + XPOS_W + 2;
    endfunction

    function automatic int code_off(input int hbits);
        return hbits + XPOS_W + 2 + PAL_W;
    endfunction

    function automatic int entry_w(input int cw, input int hbits);
        return cw + hbits + XPOS_W + 2 + PAL_W;
    endfunction

endpackage

// File: rtl/jtkiwi_objscan_fifo.sv
// Synchronous request FIFO with flush. Read data is combinational from the
// head slot; an entry written in one cycle is visible from the next.
module jtkiwi_objscan_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [0:(2**AW)-1];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/jtkiwi_objscan.sv
// Object-table scanner: selects objects crossing the next line and queues them
// for the draw engine. Optional per-line limit: JTKIWI_OBJSCAN_LIMIT_EN.
module jtkiwi_objscan
    import jtkiwi_obj_pkg::*;
#(
    parameter int         OBJW     = 9,
    parameter int         HBITS    = 4,
    parameter int         CW       = 13,
    parameter int         FAW      = 2,
    parameter logic [8:0] VB_START = VB_START_DEF,
    parameter logic [8:0] VB_END   = VB_END_DEF,
    parameter int         MAXOBJ   = 32
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lut_cen,
    input  logic            hs,
    input  logic            flip,
    input  logic            page,
    input  logic [8:0]      vdump,
    output logic [OBJW+2:0] lut_addr,
    input  logic [15:0]     lut_data,
    output logic [OBJW-1:0] y_addr,
    input  logic [7:0]      y_data,
    output logic            dr_draw,
    input  logic            dr_busy,
    output logic [CW-1:0]   dr_code,
    output logic [4:0]      dr_pal,
    output logic            dr_hflip,
    output logic            dr_vflip,
    output logic [8:0]      dr_xpos,
    output logic [HBITS-1:0] dr_ysub,
    output logic            done,
    output logic            ovf
);

    localparam int EW = entry_w(CW, HBITS);
    localparam int XO = xpos_off(HBITS);
    localparam int VO = vflip_off(HBITS);
    localparam int HO = hflip_off(HBITS);
    localparam int PO = pal_off(HBITS);
    localparam int CO = code_off(HBITS);

    scan_state_t     state, state_nx;
    logic [OBJW-1:0] objcnt;
    logic [8:0]      vf;
    logic [8:0]      ydiff;
    logic            match;
    logic            restart;
    logic            step;
    logic            half;
    logic            cnt_dec, push, lat_chk, lat_a0, lat_a1;
    logic            limit_hit;
    logic            done_set;

    logic [HBITS-1:0] ysub;
    logic [15:0]      code;
    logic [4:0]       pal;
    logic [8:0]       xpos;
    logic             hflip, vflip;

    logic [EW-1:0]   wdata, rdata;
    logic            fifo_full, fifo_empty;
    logic            draw_go;
    logic            unused_bits;

    assign vf      = {9{flip}} ^ (vdump - 9'd1);
    assign ydiff   = {1'b0, vf[7:0]} - {1'b0, y_data};
    assign match   = (ydiff[8:HBITS] == '0);
    assign restart = hs | ((vdump > VB_START) && (vdump < VB_END));
    assign step    = lut_cen & ~done;
    assign half    = (state == A0) || (state == A1);

    assign lut_addr = {page, 1'b0, ~half, objcnt};
    assign y_addr   = objcnt;

    always_comb begin
        state_nx = state;
        cnt_dec  = 1'b0;
        push     = 1'b0;
        lat_chk  = 1'b0;
        lat_a0   = 1'b0;
        lat_a1   = 1'b0;
        if (restart) begin
            state_nx = CHK;
        end else if (step) begin
            case (state)
                CHK: begin
                    lat_chk = 1'b1;
                    if (match) state_nx = A0;
                    else       cnt_dec  = 1'b1;
                end
                A0: begin
                    lat_a0   = 1'b1;
                    state_nx = A1;
                end
                A1: begin
                    lat_a1   = 1'b1;
                    state_nx = PUSH;
                end
                PUSH: begin
                    if (!fifo_full) begin
                        push     = 1'b1;
                        cnt_dec  = 1'b1;
                        state_nx = CHK;
                    end
                end
                default: state_nx = CHK;
            endcase
        end
    end

    // The down-counter wrapping past zero marks the end of the table walk
    assign done_set = (cnt_dec && (objcnt == '0)) || limit_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CHK;
            objcnt <= '1;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            if (restart) begin
                objcnt <= '1;
                done   <= 1'b0;
            end else begin
                if (cnt_dec)  objcnt <= objcnt - 1'b1;
                if (done_set) done   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lat_chk) ysub <= ydiff[HBITS-1:0];
        if (lat_a0)  {pal, code[15:14], xpos} <= lut_data;
        if (lat_a1)  {hflip, vflip, code[13:0]} <= lut_data;
    end

    assign wdata = {code[CW-1:0], pal, hflip, vflip, xpos, ysub};

    jtkiwi_objscan_fifo #(
        .W  (EW),
        .AW (FAW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (push),
        .wdata (wdata),
        .pop   (draw_go),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Skipping a cycle after each pulse gives the drawer time to raise busy
    assign draw_go = ~fifo_empty & ~dr_busy & ~dr_draw & ~restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_draw  <= 1'b0;
            dr_code  <= '0;
            dr_pal   <= '0;
            dr_hflip <= 1'b0;
            dr_vflip <= 1'b0;
            dr_xpos  <= '0;
            dr_ysub  <= '0;
        end else begin
            dr_draw <= draw_go;
            if (draw_go) begin
                dr_code  <= rdata[CO +: CW];
                dr_pal   <= rdata[PO +: PAL_W];
                dr_hflip <= rdata[HO];
                dr_vflip <= rdata[VO];
                dr_xpos  <= rdata[XO +: XPOS_W];
                dr_ysub  <= rdata[YSUB_OFF +: HBITS];
            end
        end
    end

`ifdef JTKIWI_OBJSCAN_LIMIT_EN
    localparam int LCW = $clog2(MAXOBJ + 1);

    logic [LCW-1:0] line_cnt;
    logic           ovf_q;

    assign limit_hit = push && (line_cnt == LCW'(MAXOBJ - 1));
    assign ovf       = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (restart) begin
            line_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (push) begin
            line_cnt <= line_cnt + 1'b1;
            if (limit_hit) ovf_q <= 1'b1;
        end
    end
`else
    logic [31:0] unused_maxobj;

    assign limit_hit     = 1'b0;
    assign ovf           = 1'b0;
    assign unused_maxobj = MAXOBJ;
`endif

    assign unused_bits = ^{vf[8], code};

endmodule

// File: tb/tb_jtkiwi_objscan.sv
// Directed bench for jtkiwi_objscan with a draw-order scoreboard.
module tb_jtkiwi_objscan;

    localparam int OBJW   = 4;
    localparam int CW     = 13;
    localparam int FAW    = 2;
    localparam int MAXOBJ = 4;
`ifdef JTKIWI_OBJSCAN_LIMIT_EN
    localparam int LIM   = 4;
    localparam bit LIMON = 1'b1;
`else
    localparam int LIM   = 1000;
    localparam bit LIMON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lut_cen = 1'b1;
    logic        cen_alt = 1'b0;
    logic        hs, flip, page;
    logic [8:0]  vdump;
    logic [6:0]  lut_addr, lut_addr5;
    logic [15:0] lut_data, lut_data5;
    logic [3:0]  y_addr, y_addr5;
    logic [7:0]  y_data, y_data5;
    logic        dr_draw, dr_busy, dr_draw5, dr_busy5;
    logic [CW-1:0] dr_code, dr_code5;
    logic [4:0]  dr_pal, dr_pal5;
    logic        dr_hflip, dr_vflip, dr_hflip5, dr_vflip5;
    logic [8:0]  dr_xpos, dr_xpos5;
    logic [3:0]  dr_ysub;
    logic [4:0]  dr_ysub5;
    logic        done, ovf, done5, ovf5;

    logic [15:0] lut_mem [0:127];
    logic [7:0]  y_tab [0:15];
    logic [32:0] sb [$];
    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int pulses5 = 0;
    logic [4:0] last_ysub5 = '0;
    int bcnt = 0;
    int bcnt5 = 0;
    logic hold_busy = 1'b0;

    always #5 clk = ~clk;

    jtkiwi_objscan #(.OBJW(OBJW), .HBITS(4), .CW(CW), .FAW(FAW), .MAXOBJ(MAXOBJ)) dut (
        .clk(clk), .rst_n(rst_n), .lut_cen(lut_cen), .hs(hs), .flip(flip), .page(page),
        .vdump(vdump), .lut_addr(lut_addr), .lut_data(lut_data), .y_addr(y_addr),
        .y_data(y_data), .dr_draw(dr_draw), .dr_busy(dr_busy), .dr_code(dr_code),
        .dr_pal(dr_pal), .dr_hflip(dr_hflip), .dr_vflip(dr_vflip), .dr_xpos(dr_xpos),
        .dr_ysub(dr_ysub), .done(done), .ovf(ovf));

    jtkiwi_objscan #(.OBJW(OBJW), .HBITS(5), .CW(CW), .FAW(FAW), .MAXOBJ(MAXOBJ)) dut5 (
        .clk(clk), .rst_n(rst_n), .lut_cen(lut_cen), .hs(hs), .flip(flip), .page(page),
        .vdump(vdump), .lut_addr(lut_addr5), .lut_data(lut_data5), .y_addr(y_addr5),
        .y_data(y_data5), .dr_draw(dr_draw5), .dr_busy(dr_busy5), .dr_code(dr_code5),
        .dr_pal(dr_pal5), .dr_hflip(dr_hflip5), .dr_vflip(dr_vflip5), .dr_xpos(dr_xpos5),
        .dr_ysub(dr_ysub5), .done(done5), .ovf(ovf5));

    // Table memories: Y is asynchronous, attributes come from a synchronous RAM
    assign y_data  = y_tab[y_addr];
    assign y_data5 = y_tab[y_addr5];

    always @(posedge clk) begin
        lut_cen <= cen_alt ? ~lut_cen : 1'b1;
        if (lut_cen) begin
            lut_data  <= lut_mem[lut_addr];
            lut_data5 <= lut_mem[lut_addr5];
        end
        if (dr_draw)       bcnt <= 3;
        else if (bcnt > 0) bcnt <= bcnt - 1;
        if (dr_draw5)       bcnt5 <= 3;
        else if (bcnt5 > 0) bcnt5 <= bcnt5 - 1;
    end

    assign dr_busy  = hold_busy | (bcnt != 0);
    assign dr_busy5 = (bcnt5 != 0);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] mk(input int p, input int i, input logic [3:0] ys);
        logic [13:0] c14 = 14'(i + p * 64);
        logic [4:0]  pl  = 5'(i + 3 + p);
        logic [8:0]  xp  = 9'(i * 17 + p * 100);
        logic [1:0]  ib  = 2'(i);
        logic        pb  = (p != 0);
        return {c14[12:0], pl, ib[0], ib[1] ^ pb, xp, ys};
    endfunction

    task automatic push_range(input int p, input int hi, input int lo, input logic [3:0] ys);
        int n = 0;
        for (int i = hi; i >= lo; i--) begin
            if (n < LIM) sb.push_back(mk(p, i, ys));
            n++;
        end
    endtask

    task automatic set_y(input int hi, input int lo, input logic [7:0] yin, input logic [7:0] yout);
        for (int i = 0; i < 16; i++) y_tab[i] = (i <= hi && i >= lo) ? yin : yout;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (!(done === 1'b1 && sb.size() == 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_time", 64'(k < budget), 64'd1);
        repeat (12) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dr_draw === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                chk("unexpected_draw", 64'd1, 64'd0);
            end else begin
                chk("draw_entry", {dr_code, dr_pal, dr_hflip, dr_vflip, dr_xpos, dr_ysub},
                    sb.pop_front());
            end
        end
        if (rst_n === 1'b1 && dr_draw5 === 1'b1) begin
            pulses5++;
            last_ysub5 = dr_ysub5;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 128; a++) lut_mem[a] = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                logic [1:0] ib;
                ib = 2'(i);
                lut_mem[p * 64 + 16 + i] = {5'(i + 3 + p), 2'b11, 9'(i * 17 + p * 100)};
                lut_mem[p * 64 + i]      = {ib[0], ib[1] ^ (p != 0), 14'(i + p * 64)};
            end
        end
        rst_n = 1'b0; hs = 1'b1; flip = 1'b0; page = 1'b0; vdump = 9'h058;
        set_y(15, 0, 8'h50, 8'h50);
        repeat (3) @(negedge clk);
        chk("rst_draw", dr_draw, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_yaddr", y_addr, 4'hf);
        chk("rst_lutaddr", lut_addr, 7'h1f);
        chk("rst_code_xpos", {dr_code, dr_xpos}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All 16 objects match, ysub 7, drawn 15 down to 0
        push_range(0, 15, 0, 4'd7);
        pulses = 0;
        hs = 1'b0;
        wait_drain(600);
        chk("all_match_pulses", pulses, (LIM < 16) ? LIM : 16);
        chk("all_match_done", done, 1);
        chk("all_match_ovf", ovf, LIMON);

        // ydiff = 0x10: outside a 16-line sprite, inside a 32-line one
        hs = 1'b1;
        @(negedge clk);
        vdump = 9'h061;
        pulses = 0; pulses5 = 0;
        hs = 1'b0;
        wait_drain(200);
        repeat (150) @(negedge clk);
        chk("h16_no_match", pulses, 0);
        chk("h32_pulses", pulses5, (LIM < 16) ? LIM : 16);
        chk("h32_ysub", last_ysub5, 5'h10);

        // Drawer stalled: FIFO fills after 4 entries and the scanner waits in PUSH
        hs = 1'b1;
        @(negedge clk);
        vdump = 9'h058;
        set_y(15, 8, 8'h50, 8'h00);
        hold_busy = 1'b1;
        push_range(0, 15, 8, 4'd7);
        pulses = 0;
        hs = 1'b0;
        repeat (100) @(negedge clk);
        chk("stall_no_draw", pulses, 0);
        chk("stall_yaddr", y_addr, 4'd11);
        chk("stall_done", done, LIMON);
        repeat (100) @(negedge clk);
        hold_busy = 1'b0;
        wait_drain(600);
        chk("stall_pulses", pulses, (LIM < 8) ? LIM : 8);
        chk("stall_sb_empty", sb.size(), 0);

        // hs with 3 queued entries flushes them
        hs = 1'b1;
        @(negedge clk);
        set_y(15, 13, 8'h50, 8'h00);
        hold_busy = 1'b1;
        pulses = 0;
        hs = 1'b0;
        repeat (60) @(negedge clk);
        chk("flush_pre_done", done, 1);
        hs = 1'b1;
        set_y(15, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("flush_yaddr", y_addr, 4'hf);
        chk("flush_done_clr", done, 0);
        chk("flush_no_draw", dr_draw, 0);
        hs = 1'b0;
        hold_busy = 1'b0;
        repeat (60) @(negedge clk);
        chk("flush_no_pulses", pulses, 0);
        chk("flush_rescan_done", done, 1);

        // Blanking window: no scanning at all
        hs = 1'b1;
        @(negedge clk);
        vdump = 9'h100;
        set_y(15, 0, 8'h50, 8'h50);
        pulses = 0;
        hs = 1'b0;
        repeat (40) @(negedge clk);
        chk("vb_yaddr", y_addr, 4'hf);
        chk("vb_lutaddr", lut_addr, 7'h1f);
        chk("vb_done", done, 0);
        chk("vb_pulses", pulses, 0);

        // Flip and page 1 with a gated table clock: vf = 0x1a8, y 0xa0 -> ysub 8
        flip = 1'b1;
        page = 1'b1;
        set_y(15, 0, 8'h50, 8'h50);
        y_tab[9] = 8'ha0;
        y_tab[3] = 8'ha0;
        sb.push_back(mk(1, 9, 4'd8));
        sb.push_back(mk(1, 3, 4'd8));
        cen_alt = 1'b1;
        pulses = 0;
        @(negedge clk);
        vdump = 9'h058;
        wait_drain(800);
        chk("flip_pulses", pulses, 2);
        chk("flip_lutaddr", lut_addr, 7'h5f);
        chk("flip_yaddr", y_addr, 4'hf);
        cen_alt = 1'b0;

        // Ten matches against the per-line limit
        hs = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        page = 1'b0;
        set_y(15, 6, 8'h50, 8'h00);
        push_range(0, 15, 6, 4'd7);
        pulses = 0;
        hs = 1'b0;
        wait_drain(800);
        chk("limit_pulses", pulses, (LIM < 10) ? LIM : 10);
        chk("limit_ovf", ovf, LIMON);
        chk("limit_done", done, 1);
        chk("limit_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
